// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

   typedef enum logic [1:0] {
      MD_IDLE,
      MD_BUSY,
      MD_DONE
   } md_state_t;

   // Pipeline stage indices, used to address per-stage stall/flush vectors
   localparam int STAGE_F = 0;
   localparam int STAGE_D = 1;
   localparam int STAGE_E = 2;
   localparam int STAGE_M = 3;
   localparam int STAGE_W = 4;

   localparam int DEF_MUL_CYCLES = 4;
   localparam int DEF_DIV_CYCLES = 32;
   localparam int DEF_REG_W      = 5;

endpackage

// File: rtl/hazard_ctrl_md_sequencer.sv
// Multi-cycle mul/div occupancy sequencer: tracks how long the E stage stays
// held by a mul/div, and raises md_done in the final occupancy cycle.
module md_sequencer
   import hazard_pkg::*;
#(
   parameter int MUL_CYCLES = DEF_MUL_CYCLES,
   parameter int DIV_CYCLES = DEF_DIV_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic md_start,
   input  logic md_is_div,
   input  logic dcache_miss,
   input  logic exception_m,
   output logic md_busy,
   output logic md_done,
   output logic md_accept
);

   localparam int CNT_W = $clog2(DIV_CYCLES + 1);
   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 2);
   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 2);

   md_state_t        state;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] load_value;

   assign load_value = md_is_div ? DIV_LOAD : MUL_LOAD;
   assign md_accept  = !reset && (state == MD_IDLE) && md_start && !dcache_miss && !exception_m;
   assign md_busy    = !reset && (state == MD_BUSY);
   assign md_done    = !reset && (state == MD_DONE);

   // The accepting cycle is occupancy cycle 1, so a zero load skips BUSY entirely
   always_ff @(posedge clk) begin
      if (reset || exception_m) begin
         state <= MD_IDLE;
         count <= '0;
      end else begin
         case (state)
            MD_IDLE: begin
               if (md_accept) begin
                  count <= load_value;
                  state <= (load_value == '0) ? MD_DONE : MD_BUSY;
               end
            end
            MD_BUSY: begin
               count <= count - 1'b1;
               if (count == CNT_W'(1)) begin
                  state <= MD_DONE;
               end
            end
            MD_DONE: begin
               if (!dcache_miss) begin
                  state <= MD_IDLE;
               end
            end
            default: state <= MD_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Central stall/flush generator for the 5-stage pipeline.
// Optional macro HAZARD_DELAY_SLOT_EN: mispredict flushes only D, keeping the delay slot.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int MUL_CYCLES = DEF_MUL_CYCLES,
   parameter int DIV_CYCLES = DEF_DIV_CYCLES,
   parameter int REG_W      = DEF_REG_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic             ex_mem_read,
   input  logic             ex_reg_write,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             md_start,
   input  logic             md_is_div,
   input  logic             mispredict_ex,
   input  logic             exception_m,
   input  logic             icache_miss,
   input  logic             dcache_miss,
   output logic             stall_f,
   output logic             stall_d,
   output logic             stall_e,
   output logic             stall_m,
   output logic             stall_w,
   output logic             flush_d,
   output logic             flush_e,
   output logic             flush_m,
   output logic             flush_w,
   output logic             md_busy,
   output logic             md_done
);

   logic                   md_accept;
   logic                   md_occupy;
   logic                   load_use;
   logic [STAGE_W:STAGE_F] stall_vec;
   logic [STAGE_W:STAGE_D] flush_vec;

   md_sequencer #(
      .MUL_CYCLES (MUL_CYCLES),
      .DIV_CYCLES (DIV_CYCLES)
   ) u_md_sequencer (
      .clk         (clk),
      .reset       (reset),
      .md_start    (md_start),
      .md_is_div   (md_is_div),
      .dcache_miss (dcache_miss),
      .exception_m (exception_m),
      .md_busy     (md_busy),
      .md_done     (md_done),
      .md_accept   (md_accept)
   );

   assign md_occupy = md_busy || md_accept;
   assign load_use  = ex_mem_read && ex_reg_write && (ex_rd != '0) &&
                      ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));

   // Strict priority: the first asserted condition alone decides every stall/flush
   always_comb begin
      stall_vec = '0;
      flush_vec = '0;
      if (reset) begin
         stall_vec = '0;
      end else if (exception_m) begin
         flush_vec = '1;
      end else if (dcache_miss) begin
         stall_vec[STAGE_F] = 1'b1;
         stall_vec[STAGE_D] = 1'b1;
         stall_vec[STAGE_E] = 1'b1;
         stall_vec[STAGE_M] = 1'b1;
         flush_vec[STAGE_W] = 1'b1;
      end else if (md_occupy) begin
         stall_vec[STAGE_F] = 1'b1;
         stall_vec[STAGE_D] = 1'b1;
         stall_vec[STAGE_E] = 1'b1;
         flush_vec[STAGE_M] = 1'b1;
      end else if (load_use) begin
         stall_vec[STAGE_F] = 1'b1;
         stall_vec[STAGE_D] = 1'b1;
         flush_vec[STAGE_E] = 1'b1;
      end else if (mispredict_ex) begin
         flush_vec[STAGE_D] = 1'b1;
`ifdef HAZARD_DELAY_SLOT_EN
         flush_vec[STAGE_E] = 1'b0;
`else
         flush_vec[STAGE_E] = 1'b1;
`endif
      end else if (icache_miss) begin
         stall_vec[STAGE_F] = 1'b1;
         flush_vec[STAGE_D] = 1'b1;
      end
   end

   assign stall_f = stall_vec[STAGE_F];
   assign stall_d = stall_vec[STAGE_D];
   assign stall_e = stall_vec[STAGE_E];
   assign stall_m = stall_vec[STAGE_M];
   assign stall_w = stall_vec[STAGE_W];
   assign flush_d = flush_vec[STAGE_D];
   assign flush_e = flush_vec[STAGE_E];
   assign flush_m = flush_vec[STAGE_M];
   assign flush_w = flush_vec[STAGE_W];

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios followed by random traffic,
// each cycle checked against a cycle-count reference model of the hazard rules.
module tb_hazard_ctrl;

   localparam int MUL_CYCLES = 4;
   localparam int DIV_CYCLES = 32;
   localparam int REG_W      = 5;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [REG_W-1:0] id_rs = '0;
   logic [REG_W-1:0] id_rt = '0;
   logic             id_uses_rs = 1'b0;
   logic             id_uses_rt = 1'b0;
   logic             ex_mem_read = 1'b0;
   logic             ex_reg_write = 1'b0;
   logic [REG_W-1:0] ex_rd = '0;
   logic             md_start = 1'b0;
   logic             md_is_div = 1'b0;
   logic             mispredict_ex = 1'b0;
   logic             exception_m = 1'b0;
   logic             icache_miss = 1'b0;
   logic             dcache_miss = 1'b0;
   logic             stall_f, stall_d, stall_e, stall_m, stall_w;
   logic             flush_d, flush_e, flush_m, flush_w;
   logic             md_busy, md_done;

   always #5 clk = ~clk;

   hazard_ctrl #(
      .MUL_CYCLES (MUL_CYCLES),
      .DIV_CYCLES (DIV_CYCLES),
      .REG_W      (REG_W)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .id_rs         (id_rs),
      .id_rt         (id_rt),
      .id_uses_rs    (id_uses_rs),
      .id_uses_rt    (id_uses_rt),
      .ex_mem_read   (ex_mem_read),
      .ex_reg_write  (ex_reg_write),
      .ex_rd         (ex_rd),
      .md_start      (md_start),
      .md_is_div     (md_is_div),
      .mispredict_ex (mispredict_ex),
      .exception_m   (exception_m),
      .icache_miss   (icache_miss),
      .dcache_miss   (dcache_miss),
      .stall_f       (stall_f),
      .stall_d       (stall_d),
      .stall_e       (stall_e),
      .stall_m       (stall_m),
      .stall_w       (stall_w),
      .flush_d       (flush_d),
      .flush_e       (flush_e),
      .flush_m       (flush_m),
      .flush_w       (flush_w),
      .md_busy       (md_busy),
      .md_done       (md_done)
   );

   typedef struct packed {
      logic             reset;
      logic [REG_W-1:0] id_rs;
      logic [REG_W-1:0] id_rt;
      logic             id_uses_rs;
      logic             id_uses_rt;
      logic             ex_mem_read;
      logic             ex_reg_write;
      logic [REG_W-1:0] ex_rd;
      logic             md_start;
      logic             md_is_div;
      logic             mispredict_ex;
      logic             exception_m;
      logic             icache_miss;
      logic             dcache_miss;
   } stim_t;

   // Output vector order: {stall_f,d,e,m,w, flush_d,e,m,w, md_busy, md_done}
   logic [10:0] exp_q[$];
   string       tag_q[$];
   int          checks = 0;
   int          failures = 0;

   // Reference model: md_pos is the occupancy cycle number the unit is in
   // (0 = no mul/div held, md_total or beyond = result cycle)
   int md_pos = 0;
   int md_total = 0;

   function automatic stim_t quiet();
      stim_t s;
      s = '0;
      return s;
   endfunction

   function automatic logic [10:0] modelOutputs(input stim_t s);
      logic [4:0] st;
      logic [3:0] fl;
      logic       busy, done, accept, lu;
      st     = '0;
      fl     = '0;
      busy   = (md_pos >= 2) && (md_pos < md_total);
      done   = (md_pos != 0) && (md_pos >= md_total);
      accept = (md_pos == 0) && s.md_start && !s.dcache_miss && !s.exception_m;
      lu     = s.ex_mem_read && s.ex_reg_write && (s.ex_rd != 0) &&
               ((s.id_uses_rs && s.id_rs == s.ex_rd) || (s.id_uses_rt && s.id_rt == s.ex_rd));
      if (s.reset) return '0;
      if (s.exception_m) fl = 4'b1111;
      else if (s.dcache_miss) begin st = 5'b11110; fl = 4'b0001; end
      else if (busy || accept) begin st = 5'b11100; fl = 4'b0010; end
      else if (lu) begin st = 5'b11000; fl = 4'b0100; end
      else if (s.mispredict_ex) begin
`ifdef HAZARD_DELAY_SLOT_EN
         fl = 4'b1000;
`else
         fl = 4'b1100;
`endif
      end
      else if (s.icache_miss) begin st = 5'b10000; fl = 4'b1000; end
      return {st, fl, busy, done};
   endfunction

   task automatic modelAdvance(input stim_t s);
      if (s.reset || s.exception_m) md_pos = 0;
      else if (md_pos == 0) begin
         if (s.md_start && !s.dcache_miss) begin
            md_total = s.md_is_div ? DIV_CYCLES : MUL_CYCLES;
            md_pos   = 2;
         end
      end
      else if (md_pos < md_total) md_pos++;
      else if (!s.dcache_miss) md_pos = 0;
   endtask

   task automatic applyStimulus(input stim_t s, input string tag);
      @(posedge clk);
      #1;
      reset         = s.reset;
      id_rs         = s.id_rs;
      id_rt         = s.id_rt;
      id_uses_rs    = s.id_uses_rs;
      id_uses_rt    = s.id_uses_rt;
      ex_mem_read   = s.ex_mem_read;
      ex_reg_write  = s.ex_reg_write;
      ex_rd         = s.ex_rd;
      md_start      = s.md_start;
      md_is_div     = s.md_is_div;
      mispredict_ex = s.mispredict_ex;
      exception_m   = s.exception_m;
      icache_miss   = s.icache_miss;
      dcache_miss   = s.dcache_miss;
      exp_q.push_back(modelOutputs(s));
      tag_q.push_back(tag);
      modelAdvance(s);
   endtask

   task automatic checkOutput(input string tag, input logic [10:0] expected);
      logic [10:0] actual;
      actual = {stall_f, stall_d, stall_e, stall_m, stall_w,
                flush_d, flush_e, flush_m, flush_w, md_busy, md_done};
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s at %0t: got %b expected %b (sf sd se sm sw fd fe fm fw busy done)",
                  tag, $time, actual, expected);
      end
   endtask

   // Monitor: outputs are valid every cycle, sampled mid-cycle on the falling edge
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         logic [10:0] e;
         string       t;
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         checkOutput(t, e);
      end
   end

   initial begin
      stim_t s;

      s = quiet(); s.reset = 1'b1;
      repeat (2) applyStimulus(s, "reset");
      applyStimulus(quiet(), "idle");

      s = quiet(); s.ex_mem_read = 1; s.ex_reg_write = 1; s.ex_rd = 5; s.id_rs = 5; s.id_uses_rs = 1;
      applyStimulus(s, "load_use");
      applyStimulus(quiet(), "load_use_bubble");
      s.ex_rd = 0; s.id_rs = 0;
      applyStimulus(s, "load_use_rd0");
      s = quiet(); s.ex_mem_read = 1; s.ex_reg_write = 1; s.ex_rd = 7; s.id_rt = 7; s.id_uses_rt = 1;
      applyStimulus(s, "load_use_rt");

      s = quiet(); s.md_start = 1;
      for (int k = 1; k <= MUL_CYCLES; k++) applyStimulus(s, "mul_occ");
      applyStimulus(quiet(), "mul_after");

      s = quiet(); s.md_start = 1; s.md_is_div = 1;
      for (int k = 1; k <= 9; k++) applyStimulus(s, "div_occ");
      s.exception_m = 1;
      applyStimulus(s, "div_exception");
      applyStimulus(quiet(), "div_abort_next");
      applyStimulus(quiet(), "div_abort_idle");

      s = quiet(); s.md_start = 1;
      for (int k = 1; k <= 3; k++) applyStimulus(s, "mul_pre_done");
      s.dcache_miss = 1;
      for (int k = 1; k <= 3; k++) applyStimulus(s, "done_dmiss");
      s.dcache_miss = 0;
      applyStimulus(s, "done_release");
      applyStimulus(quiet(), "done_no_restart");

      s = quiet(); s.mispredict_ex = 1; s.icache_miss = 1;
      applyStimulus(s, "mispredict_icache");
      s.mispredict_ex = 0;
      applyStimulus(s, "icache_only");

      s = quiet(); s.md_start = 1; s.md_is_div = 1;
      for (int k = 1; k <= 5; k++) applyStimulus(s, "div_pre_reset");
      s.reset = 1;
      repeat (2) applyStimulus(s, "reset_mid_busy");
      applyStimulus(quiet(), "post_reset");

      for (int n = 0; n < 1500; n++) begin
         s = quiet();
         s.reset         = ($urandom_range(199) == 0);
         s.id_rs         = REG_W'($urandom_range(3));
         s.id_rt         = REG_W'($urandom_range(3));
         s.id_uses_rs    = $urandom_range(1) == 1;
         s.id_uses_rt    = $urandom_range(1) == 1;
         s.ex_mem_read   = $urandom_range(1) == 1;
         s.ex_reg_write  = $urandom_range(3) != 0;
         s.ex_rd         = REG_W'($urandom_range(3));
         s.md_start      = $urandom_range(3) == 0;
         s.md_is_div     = $urandom_range(3) == 0;
         s.mispredict_ex = $urandom_range(5) == 0;
         s.exception_m   = $urandom_range(23) == 0;
         s.icache_miss   = $urandom_range(3) == 0;
         s.dcache_miss   = $urandom_range(7) == 0;
         applyStimulus(s, "random");
      end

      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("[TB] FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central stall/flush generator for the 5-stage pipeline (F, D, E, M, W).
- Drives the Stall/Flush pair of every inter-stage pipeline register. stall_X/flush_X control the register that feeds stage X.
- Detects load-use hazards, branch mispredicts, M-stage exceptions and cache misses.
- Sequences multi-cycle mul/div occupancy of E with an internal FSM and counter.

Parameters:
- MUL_CYCLES, 4, total E-stage cycles for a multiply (>=2)
- DIV_CYCLES, 32, total E-stage cycles for a divide (>=2)
- REG_W, 5, register-specifier width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- id_rs, id_rt  in  REG_W  source specifiers of instruction in D
- id_uses_rs, id_uses_rt  in  1  D actually reads rs/rt
- ex_mem_read  in  1  E instruction is a load
- ex_reg_write  in  1  E instruction writes a register
- ex_rd  in  REG_W  E destination specifier
- md_start  in  1  E holds a mul/div instruction
- md_is_div  in  1  qualifies md_start: 1=div, 0=mul
- mispredict_ex  in  1  branch in E resolved mispredicted
- exception_m  in  1  instruction in M raised an exception
- icache_miss  in  1  F fetch not ready
- dcache_miss  in  1  M access not ready
- stall_f, stall_d, stall_e, stall_m, stall_w  out  1  hold the register feeding that stage
- flush_d, flush_e, flush_m, flush_w  out  1  clear the register feeding that stage (bubble)
- md_busy  out  1  FSM in BUSY
- md_done  out  1  mul/div result valid this cycle

Behaviour:
- Outputs are combinational from FSM state and inputs. The only state is the md FSM plus its counter, width $clog2(DIV_CYCLES+1).
- Reset: FSM=IDLE, counter=0. During reset cycles all stall_* and flush_* are driven 0; md_busy=0, md_done=0.
- Flush dominates stall in the downstream register. The bench checks only required-1 outputs; all other outputs are 0.
- Priority, highest first:
  1. exception_m: flush_d, flush_e, flush_m, flush_w = 1; all stalls 0; FSM forced to IDLE next cycle (abort).
  2. dcache_miss: stall_f, stall_d, stall_e, stall_m = 1; flush_w = 1.
  3. md occupancy (BUSY, or IDLE with md_start accepted): stall_f, stall_d, stall_e = 1; flush_m = 1.
  4. load-use: ex_mem_read & ex_reg_write & ex_rd!=0 & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)). Drives stall_f, stall_d = 1 and flush_e = 1. Exactly one bubble per load.
  5. mispredict_ex: flush_d = 1 and flush_e = 1 (see optional feature).
  6. icache_miss: stall_f = 1; flush_d = 1.
- Lower-priority conditions are ignored in a cycle where a higher one asserts. mispredict_ex remains asserted while its branch is held in E, so it takes effect when released.
- stall_w is always 0 (W has no downstream hold).
- md FSM, IDLE:
  - md_start & !dcache_miss & !exception_m -> BUSY.
  - counter loads (md_is_div ? DIV_CYCLES : MUL_CYCLES) - 2.
  - The accepting cycle counts as occupancy cycle 1.
- md FSM, BUSY:
  - md_busy=1; md_start ignored.
  - counter decrements each cycle.
  - counter==0 -> DONE.
- md FSM, DONE:
  - md_done=1; no md stall, so E advances.
  - -> IDLE unless dcache_miss (stall_e) is active; then DONE holds with md_done=1.
- Total E occupancy = MUL_CYCLES or DIV_CYCLES, including the DONE cycle.
- Simultaneous md_start and load-use with D: md stall covers it. Load-use is re-evaluated after E advances.
- Reset mid-BUSY: returns to IDLE next edge; no md_done pulse.

Optional Feature:
- Macro: HAZARD_DELAY_SLOT_EN.
- Defined: MIPS branch delay slot honoured. On mispredict only flush_d=1; the delay-slot instruction in D proceeds to E.
- Undefined: mispredict flushes both D and E registers as listed above.

Decomposition:
- Shared package (hazard_pkg):
  - md_state_t enum {MD_IDLE, MD_BUSY, MD_DONE}.
  - stage index constants.
  - default latency constants.
- One natural sub-module: md_sequencer, holding the FSM and counter. Outputs md_busy, md_done and md_accept.
- Top level contains only the priority-combining logic.

Test Plan:
- Load-use: ex_mem_read=1, ex_reg_write=1, ex_rd=5, id_rs=5, id_uses_rs=1. Required: stall_f=stall_d=flush_e=1 for one cycle. With ex_rd=0, no stall.
- Mul: md_start=1, md_is_div=0 for one accepted cycle, held while stalled. Required: stall_e=1 for exactly 3 cycles, then md_done=1 in the 4th cycle with stall_e=0. Div: 31 stall cycles, then done.
- Exception_m pulsed in BUSY cycle 10 of a div. Required: flush_d/e/m/w=1, all stalls 0 that cycle; md_busy=0 next cycle; no md_done.
- dcache_miss held 3 cycles while md in DONE. Required: md_done stays 1 all 3 cycles, flush_w=1; FSM returns to IDLE after the miss, with no restart.
- mispredict_ex together with icache_miss. Required: flush_d=flush_e=1, stall_f=0. With HAZARD_DELAY_SLOT_EN: flush_d=1, flush_e=0.
- reset=1 during BUSY. Required: all outputs 0 while reset; first post-reset cycle md_busy=0.
